// File: rtl/conv_pkg.sv
// Shared types for the convolution engine result path: lane geometry, packed
// result word, reader FSM states and the lane clamp used by the ReLU build.
package conv_pkg;

    localparam int LANE_W    = 16;
    localparam int NUM_LANES = 4;
    localparam int RES_W     = 64;

    typedef logic [RES_W-1:0] res_word_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_CAPTURE,
        ST_DRAIN
    } rdr_state_e;

    // Negative lanes (MSB set) become zero; the others pass through untouched.
    function automatic res_word_t relu_clamp(input res_word_t w);
        res_word_t r;
        r = w;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (w[l*LANE_W + LANE_W - 1]) begin
                r[l*LANE_W +: LANE_W] = '0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/conv_result_fifo.sv
// First-word-fall-through FIFO for 64-bit result words; a push into a full FIFO
// is still accepted when a pop happens on the same edge.
module conv_result_fifo
    import conv_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic                     pop,
    input  res_word_t                din,
    output res_word_t                dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    res_word_t       mem [DEPTH];
    logic [AW-1:0]   wr_q;
    logic [AW-1:0]   rd_q;
    logic [AW:0]     cnt_q;
    logic            do_push;
    logic            do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_q];
    assign count   = cnt_q;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_q] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/conv_result_reader.sv
// Captures engine result words into a FIFO and streams them out as 32-bit halves.
// Build option RESULT_RELU_EN clamps negative lanes to zero at capture.
//
//   state      | meaning
//   IDLE       | waiting for start; frame_done holds the last frame's status
//   ARMED      | frame armed, no word captured yet
//   CAPTURE    | capturing valid engine words until eng_done
//   DRAIN      | capture closed, waiting for the FIFO and half-select to empty
module conv_result_reader
    import conv_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [RES_W-1:0]  eng_dout,
    input  logic              eng_st_out,
    input  logic              eng_done,
    output logic [31:0]       out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  word_count,
    output logic              overflow
);

    localparam int AW = $clog2(DEPTH);

    rdr_state_e        state_q, state_d;
    logic              half_q, half_d;
    logic [CNT_W-1:0]  wcnt_q, wcnt_d;
    logic              ovf_q, ovf_d;
    logic              fdone_q, fdone_d;

    logic              cap;
    logic              hs;
    logic              pop;
    logic              push_req;
    logic              fifo_clr;
    logic              fifo_empty;
    logic              fifo_full;
    logic [AW:0]       fifo_count;
    res_word_t         wr_word;
    res_word_t         rd_word;

    assign cap = eng_st_out & ~eng_done;
    assign hs  = out_valid & out_ready;
    assign pop = hs & half_q;

`ifdef RESULT_RELU_EN
    assign wr_word = relu_clamp(eng_dout);
`else
    assign wr_word = eng_dout;
`endif

    conv_result_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (push_req),
        .pop   (pop),
        .din   (wr_word),
        .dout  (rd_word),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        wcnt_d   = wcnt_q;
        ovf_d    = ovf_q;
        fdone_d  = fdone_q;
        push_req = 1'b0;
        fifo_clr = 1'b0;
        half_d   = hs ? ~half_q : half_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d  = ST_ARMED;
                    fdone_d  = 1'b0;
                    wcnt_d   = '0;
                    ovf_d    = 1'b0;
                    fifo_clr = 1'b1;
                end
            end
            ST_ARMED: begin
                if (eng_done) begin
                    state_d = ST_DRAIN;
                end else if (cap) begin
                    state_d  = ST_CAPTURE;
                    push_req = 1'b1;
                end
            end
            ST_CAPTURE: begin
                if (eng_done) begin
                    state_d = ST_DRAIN;
                end else if (cap) begin
                    push_req = 1'b1;
                end
            end
            ST_DRAIN: begin
                if ((fifo_count == '0) && !half_q) begin
                    state_d = ST_IDLE;
                    fdone_d = 1'b1;
                end
            end
        endcase

        // A dropped word still counts as captured.
        if (push_req) begin
            if (wcnt_q != '1) wcnt_d = wcnt_q + CNT_W'(1);
            if (fifo_full && !pop) ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            half_q  <= 1'b0;
            wcnt_q  <= '0;
            ovf_q   <= 1'b0;
            fdone_q <= 1'b0;
        end else begin
            state_q <= state_d;
            half_q  <= half_d;
            wcnt_q  <= wcnt_d;
            ovf_q   <= ovf_d;
            fdone_q <= fdone_d;
        end
    end

    assign out_valid  = ~fifo_empty;
    assign out_data   = fifo_empty ? 32'h0 : (half_q ? rd_word[31:0] : rd_word[63:32]);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = fdone_q;
    assign word_count = wcnt_q;
    assign overflow   = ovf_q;

endmodule
